// File: rtl/wb_arbiter_pkg.sv
// Shared constants and result-bus type for the register-file write-back path.
package wb_arbiter_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // One completed result heading for the register file.
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

endpackage : wb_arbiter_pkg

// File: rtl/wb_scoreboard.sv
// Per-register busy vector: set at issue, cleared at write-back, queried by decode.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector; the set is applied after the clear so a newly issued
  // writer keeps ownership when an older result to the same rd retires.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != REG_ZERO)) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

  // A second writer to a register still owned by an in-flight result is an
  // issuer bug; retiring the old result on the same edge is fine.
  waw_issue_a : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(set_en && (set_rd != REG_ZERO) && busy_q[set_rd] &&
        !(clr_en && (clr_rd == set_rd)))
  ) else $error("wb_scoreboard: WAW issue to busy register %0d", set_rd);

endmodule : wb_scoreboard

// File: rtl/wb_arbiter.sv
// Write-back arbiter: LSU/MDU results win over ALU results for the single
// register-file write port; the write is registered (one cycle latency).
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_wen,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_wdata
);

  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t grant_req;

  logic            wb_wen_q,   wb_wen_d;
  logic [AW-1:0]   wb_addr_q,  wb_addr_d;
  logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
  logic            clr_en;

  assign alu_req = {alu_valid, alu_rd, alu_wdata};
  assign lsu_req = {lsu_valid, lsu_rd, lsu_wdata};

  // The LSU/MDU path cannot be back-pressured, so it is always ready and the
  // ALU only gets the port when the LSU is idle.
  assign lsu_ready = 1'b1;
  assign alu_ready = ~lsu_valid;

  // Fixed-priority grant selection.
  always_comb begin
    grant_req = '0;
    if (lsu_req.valid) begin
      grant_req = lsu_req;
    end else if (alu_req.valid) begin
      grant_req = alu_req;
    end
  end

  // Output register next state; address/data hold when nothing is granted,
  // and an x0 result is consumed without a write.
  always_comb begin
    wb_wen_d   = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_wdata_d = wb_wdata_q;
    if (grant_req.valid) begin
      wb_wen_d   = (grant_req.rd != REG_ZERO);
      wb_addr_d  = grant_req.rd;
      wb_wdata_d = grant_req.wdata;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wen_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_wdata_q <= '0;
    end else begin
      wb_wen_q   <= wb_wen_d;
      wb_addr_q  <= wb_addr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_wen   = wb_wen_q;
  assign wb_addr  = wb_addr_q;
  assign wb_wdata = wb_wdata_q;

  // Busy clears on the same edge that loads the write port, so decode sees the
  // register free while the regfile bypass supplies the value.
  assign clr_en = grant_req.valid && (grant_req.rd != REG_ZERO);

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_en),
    .set_rd   (issue_rd),
    .clr_en   (clr_en),
    .clr_rd   (grant_req.rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wb_wen;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_wdata;

  int n_vec;
  int n_err;

  wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_wdata (alu_wdata),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_wdata (lsu_wdata),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wb_wen    (wb_wen),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable after #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_wb(input string tag, input logic wen,
                          input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
    chk({tag, ".wen"},   64'(wb_wen),   64'(wen));
    chk({tag, ".addr"},  64'(wb_addr),  64'(addr));
    chk({tag, ".wdata"}, 64'(wb_wdata), 64'(data));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
    issue_en = 1'b0;  issue_rd = '0;
    rs1_addr = '0;    rs2_addr = '0;

    // Reset state, readies are combinational and high during reset.
    tick();
    tick();
    check_wb("reset", 1'b0, '0, '0);
    chk("reset.lsu_ready", 64'(lsu_ready), 64'd1);
    chk("reset.alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU single write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 64'h1234;
    settle();
    chk("alu1.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_wb("alu1.c1", 1'b1, 5'd5, 64'h1234);
    tick();
    check_wb("alu1.c2", 1'b0, 5'd5, 64'h1234);

    // LSU/ALU collision: LSU first, held ALU next.
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 64'hAA;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wdata = 64'hBB;
    settle();
    chk("coll.alu_ready0", 64'(alu_ready), 64'd0);
    chk("coll.lsu_ready0", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    check_wb("coll.c1", 1'b1, 5'd7, 64'hAA);
    settle();
    chk("coll.alu_ready1", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_wb("coll.c2", 1'b1, 5'd9, 64'hBB);
    tick();
    chk("coll.c3.wen", 64'(wb_wen), 64'd0);

    // Scoreboard lifecycle on rd=3.
    issue_en = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
    settle();
    chk("sb.c0.busy", 64'(rs1_busy), 64'd0);
    tick();
    issue_en = 1'b0;
    chk("sb.c1.busy", 64'(rs1_busy), 64'd1);
    tick();
    tick();
    tick();
    chk("sb.c4.busy", 64'(rs1_busy), 64'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 64'h33;
    tick();
    lsu_valid = 1'b0;
    chk("sb.c5.busy", 64'(rs1_busy), 64'd0);
    check_wb("sb.c5", 1'b1, 5'd3, 64'h33);

    // Set and clear of rd=4 on the same edge: set wins.
    issue_en = 1'b1; issue_rd = 5'd4; rs2_addr = 5'd4;
    tick();
    chk("sc.pre.busy", 64'(rs2_busy), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wdata = 64'h44;
    tick();
    issue_en = 1'b0; alu_valid = 1'b0;
    chk("sc.busy", 64'(rs2_busy), 64'd1);
    check_wb("sc", 1'b1, 5'd4, 64'h44);
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 64'h45;
    tick();
    lsu_valid = 1'b0;
    chk("sc.retire.busy", 64'(rs2_busy), 64'd0);

    // x0 result is consumed but never written; x0 never goes busy.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 64'hDEAD;
    issue_en = 1'b1; issue_rd = 5'd0; rs2_addr = 5'd0;
    settle();
    chk("x0.alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0; issue_en = 1'b0;
    chk("x0.wen", 64'(wb_wen), 64'd0);
    chk("x0.addr", 64'(wb_addr), 64'd0);
    chk("x0.busy", 64'(rs2_busy), 64'd0);
    tick();
    chk("x0.wen2", 64'(wb_wen), 64'd0);

    // Asynchronous reset in the middle of activity.
    issue_en = 1'b1; issue_rd = 5'd10; rs1_addr = 5'd10;
    tick();
    issue_en = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wdata = 64'h55;
    tick();
    check_wb("mid.pre", 1'b1, 5'd11, 64'h55);
    chk("mid.pre.busy", 64'(rs1_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_wb("mid.rst", 1'b0, '0, '0);
    chk("mid.rst.busy", 64'(rs1_busy), 64'd0);
    lsu_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_wb("mid.post", 1'b0, '0, '0);
    tick();
    chk("mid.post2.wen", 64'(wb_wen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writer end of the integer register file. Arbitrates completed results from the single-cycle ALU path and the multi-cycle LSU/MDU path onto the register file's single write port (wen/addr/wdata), with a registered output. Keeps a per-register busy scoreboard, set at issue and cleared at writeback. Decode queries the scoreboard to stall on RAW hazards.

Parameters:
XLEN, 64, data width of a write-back result
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous assert, active-low
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  AW  ALU destination register
alu_wdata  in  XLEN  ALU result
lsu_valid  in  1  LSU/MDU result valid
lsu_ready  out  1  LSU/MDU result accepted this cycle
lsu_rd  in  AW  LSU/MDU destination register
lsu_wdata  in  XLEN  LSU/MDU result
issue_en  in  1  an instruction writing a register is issued this cycle
issue_rd  in  AW  destination of the issued instruction
rs1_addr  in  AW  decode source 1 query
rs2_addr  in  AW  decode source 2 query
rs1_busy  out  1  rs1 has an outstanding write
rs2_busy  out  1  rs2 has an outstanding write
wb_wen  out  1  register file write enable
wb_addr  out  AW  register file write address
wb_wdata  out  XLEN  register file write data

Behaviour:
- Reset (rst_n low, asynchronous): wb_wen=0, wb_addr=0, wb_wdata=0, busy vector all 0. Ready outputs are combinational. Under reset lsu_ready=1 and alu_ready=1, but nothing is accepted.
- Arbitration (combinational), fixed priority, LSU over ALU:
  - lsu_ready = 1.
  - alu_ready = ~lsu_valid.
  - Grant = lsu_valid ? LSU : (alu_valid ? ALU : none).
  - A handshake occurs when valid & ready. At most one grant per cycle.
- ALU producers hold alu_rd/alu_wdata stable while alu_valid & ~alu_ready. Starvation of the ALU under back-to-back LSU results is allowed.
- Output register, latency 1: on the edge after a grant, wb_wen = (granted rd != 0), wb_addr = granted rd, wb_wdata = granted data.
  - With no grant: wb_wen=0; wb_addr and wb_wdata hold their previous values.
  - A grant with rd=0 is consumed (ready asserted) but produces wb_wen=0.
- Scoreboard: NREG-bit busy vector, bit 0 tied to 0.
  - Set: issue_en & issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Clear: a grant with rd != 0 clears busy[rd] at the same edge that loads the output register. While wb_wen is high for that rd, busy is already 0 and the register file bypass supplies the data.
  - Same rd set and cleared on the same edge: set wins (newer instruction owns the register).
  - issue_en to an rd that is already busy (WAW) is illegal; the issuer must stall. Simulation-only assertion flags it.
- Query (combinational): rsN_busy = busy[rsN_addr]. rsN_addr == 0 always gives 0.
- Reset mid-operation: outputs clear immediately, the pending grant is discarded, all busy bits clear. No write is issued after reset release until a new grant.

Decomposition:
- Shared package constants: XLEN, NREG, AW, REG_ZERO.
- Shared package typedef: wb_req_t {valid, rd, wdata}, reused by ALU and LSU result interfaces.
- One sub-module, wb_scoreboard: busy vector with set/clear/query logic and the WAW assertion.
- Arbiter and output register stay in wb_arbiter.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> wb_wen, wb_addr, wb_wdata and all busy bits go to 0 without waiting for a clock edge.
- ALU single write: alu_valid=1, alu_rd=5, alu_wdata=0x1234 in cycle 0 -> alu_ready=1 in cycle 0; wb_wen=1, wb_addr=5, wb_wdata=0x1234 in cycle 1; wb_wen=0 in cycle 2.
- Collision: lsu (rd=7, 0xAA) and alu (rd=9, 0xBB) valid in cycle 0, ALU held -> alu_ready=0 in cycle 0, then 1 in cycle 1; writes rd=7/0xAA in cycle 1 and rd=9/0xBB in cycle 2.
- Scoreboard lifecycle: issue_en, rd=3 in cycle 0 -> rs1_addr=3 reads busy=1 in cycle 1. LSU result rd=3 granted in cycle 4 -> busy=0 and wb_wen=1, wb_addr=3 in cycle 5.
- Set-and-clear collision: grant rd=4 and issue_en rd=4 in the same cycle -> busy[4]=1 next cycle, while wb_wen=1 to rd 4.
- x0 handling: alu_rd=0, alu_valid=1 -> alu_ready=1 and wb_wen stays 0. issue_rd=0 -> rs2_addr=0 reads busy=0.
